decode_mt: RTL and testbench

- Multi-thread decode stage that succeeds the single-instruction combinational decoder.
- Fetch pushes tagged 32-bit instructions into per-thread instruction buffers. A round-robin arbiter selects one ready thread per cycle and decodes its head instruction into a registered output slot with a valid/ready handshake.
- Supports per-thread flush, and halts a thread after it issues an invalid instruction.
- Sits between fetch and the register-read/issue stage.

---
 rtl/decode_mt.sv | 199 +++++++++++++++++++
 tb/tb_decode_mt.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_mt.sv
// Multi-thread decode stage: per-thread instruction FIFOs, a round-robin arbiter,
// and a registered decoded-instruction slot with valid/ready handshake.
module decode_mt #(
    parameter int NUM_THREAD = 4,
    parameter int BUF_DEPTH  = 4,
    parameter int TID_W      = $clog2(NUM_THREAD)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [TID_W-1:0]      in_tid,
    input  logic [31:0]           in_ins,
    output logic                  in_ready,
    input  logic [NUM_THREAD-1:0] flush,
    output logic [NUM_THREAD-1:0] buf_full,
    output logic [NUM_THREAD-1:0] halted,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TID_W-1:0]      out_tid,
    output logic [4:0]            out_reg_rd_a,
    output logic [4:0]            out_reg_rd_b,
    output logic [4:0]            out_reg_wr,
    output logic [15:0]           out_imm,
    output logic [2:0]            out_alu_op,
    output logic                  out_wr_en,
    output logic                  out_init,
    output logic                  out_exp_jmp,
    output logic                  out_exp_return,
    output logic                  out_i_type,
    output logic                  out_invalid,
    output logic [1:0]            out_mem_ctrl,
    output logic [1:0]            out_trd_ctrl,
    output logic [3:0]            out_jmp_con
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [3:0] OP_CAL    = 4'd1;
    localparam logic [3:0] OP_CALI   = 4'd2;
    localparam logic [3:0] OP_SHIFT  = 4'd3;
    localparam logic [3:0] OP_LOADI  = 4'd4;
    localparam logic [3:0] OP_MEMOP  = 4'd5;
    localparam logic [3:0] OP_BRANCH = 4'd6;
    localparam logic [3:0] OP_EXC    = 4'd7;
    localparam logic [3:0] OP_MULTI  = 4'd8;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [4:0]       rd_a, rd_b, wr;
        logic [15:0]      imm;
        logic [2:0]       alu_op;
        logic             wr_en, init, exp_jmp, exp_return, i_type, invalid;
        logic [1:0]       mem_ctrl, trd_ctrl;
        logic [3:0]       jmp_con;
    } slot_t;

    logic [31:0]           mem_q [NUM_THREAD][BUF_DEPTH];
    logic [PW-1:0]         rd_q [NUM_THREAD];
    logic [PW-1:0]         wr_q [NUM_THREAD];
    logic [NUM_THREAD-1:0] halted_q, cand;
    logic [TID_W-1:0]      ptr_q, grant_tid, idx;
    logic                  grant_valid, push_en, slot_free, out_valid_q;
    logic [31:0]           head;
    slot_t                 slot_q, dec;

    // Full when write pointer has lapped the read pointer (extra MSB differs).
    always_comb begin
        for (int t = 0; t < NUM_THREAD; t++) begin
            buf_full[t] = (wr_q[t] - rd_q[t]) == PW'(BUF_DEPTH);
            cand[t]     = (wr_q[t] != rd_q[t]) && !halted_q[t] && !flush[t];
        end
    end

    assign in_ready  = !buf_full[in_tid] && !flush[in_tid];
    assign push_en   = in_valid && in_ready;
    // A flushed slot frees up in the same cycle so another thread can take it.
    assign slot_free = !out_valid_q || out_ready || flush[slot_q.tid];

    // NOTE: combinational blocks use blocking '=' and assign defaults first so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_tid   = '0;
        idx         = '0;
        for (int i = NUM_THREAD - 1; i >= 0; i--) begin
            idx = ptr_q + TID_W'(i);
            if (cand[idx]) begin
                grant_valid = 1'b1;
                grant_tid   = idx;
            end
        end
    end

    assign head = mem_q[grant_tid][rd_q[grant_tid][AW-1:0]];

    always_comb begin
        dec        = '0;
        dec.tid    = grant_tid;
        dec.rd_a   = head[26:22];
        dec.wr     = head[31:27];
        dec.imm    = head[25:10];
        dec.alu_op = head[7:5];
        dec.rd_b   = (head[4:1] == OP_BRANCH || head[4:1] == OP_MEMOP) ? head[31:27] : head[21:17];
        case (head[4:1])
            OP_CAL, OP_SHIFT: dec.wr_en = 1'b1;
            OP_CALI, OP_LOADI: begin
                dec.wr_en  = 1'b1;
                dec.i_type = 1'b1;
            end
            OP_MEMOP: begin
                dec.i_type   = 1'b1;
                dec.mem_ctrl = head[8] ? 2'b01 : 2'b10;
                dec.wr_en    = head[8];
            end
            OP_BRANCH: begin
                case (head[7:5])
                    3'b000:  begin dec.jmp_con = 4'b0111; dec.wr_en = 1'b1; end
                    3'b010:  begin dec.jmp_con = 4'b1111; dec.wr_en = 1'b1; end
                    3'b001:  dec.jmp_con = 4'b0001;
                    3'b011:  dec.jmp_con = 4'b0100;
                    3'b111:  dec.jmp_con = 4'b0010;
                    default: dec.invalid = 1'b1;
                endcase
            end
            OP_EXC: begin
                if (head[5])      dec.exp_jmp    = 1'b1;
                else if (head[6]) dec.exp_return = 1'b1;
                else              dec.invalid    = 1'b1;
            end
            OP_MULTI: begin
                case (head[7:5])
                    3'b111:  begin dec.init = 1'b1; dec.wr_en = 1'b1; end
                    3'b101:  dec.trd_ctrl = 2'b01;
                    3'b010:  dec.trd_ctrl = 2'b10;
                    3'b000:  dec.trd_ctrl = 2'b11;
                    default: dec.invalid = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // NOTE: the instruction storage carries no reset; pointers alone define buffer contents.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[in_tid][wr_q[in_tid][AW-1:0]] <= in_ins;
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREAD; t++) begin
                rd_q[t] <= '0;
                wr_q[t] <= '0;
            end
            halted_q    <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            slot_q      <= '0;
        end else begin
            for (int t = 0; t < NUM_THREAD; t++) begin
                if (flush[t]) begin
                    rd_q[t]     <= '0;
                    wr_q[t]     <= '0;
                    halted_q[t] <= 1'b0;
                end else begin
                    if (push_en && in_tid == TID_W'(t)) wr_q[t] <= wr_q[t] + 1'b1;
                    if (slot_free && grant_valid && grant_tid == TID_W'(t)) begin
                        rd_q[t] <= rd_q[t] + 1'b1;
                        if (dec.invalid) halted_q[t] <= 1'b1;
                    end
                end
            end
            if (slot_free) begin
                out_valid_q <= grant_valid;
                if (grant_valid) begin
                    slot_q <= dec;
                    ptr_q  <= grant_tid + 1'b1;
                end
            end
        end
    end

    assign halted         = halted_q;
    assign out_valid      = out_valid_q;
    assign out_tid        = slot_q.tid;
    assign out_reg_rd_a   = slot_q.rd_a;
    assign out_reg_rd_b   = slot_q.rd_b;
    assign out_reg_wr     = slot_q.wr;
    assign out_imm        = slot_q.imm;
    assign out_alu_op     = slot_q.alu_op;
    assign out_wr_en      = slot_q.wr_en;
    assign out_init       = slot_q.init;
    assign out_exp_jmp    = slot_q.exp_jmp;
    assign out_exp_return = slot_q.exp_return;
    assign out_i_type     = slot_q.i_type;
    assign out_invalid    = slot_q.invalid;
    assign out_mem_ctrl   = slot_q.mem_ctrl;
    assign out_trd_ctrl   = slot_q.trd_ctrl;
    assign out_jmp_con    = slot_q.jmp_con;
endmodule

// File: tb/tb_decode_mt.sv
// Directed bench for decode_mt: per-thread expected queues filled at push time,
// popped and compared whenever the output slot handshakes.
module tb_decode_mt;
    localparam logic [3:0] CAL = 4'd1, CALI = 4'd2, SHIFT = 4'd3, LOADI = 4'd4;
    localparam logic [3:0] MEMOP = 4'd5, BRANCH = 4'd6, EXC = 4'd7, MULTI = 4'd8;

    typedef struct packed {
        logic [1:0]  tid;
        logic [4:0]  rd_a, rd_b, wr;
        logic [15:0] imm;
        logic [2:0]  alu;
        logic        wr_en, init, exp_jmp, exp_ret, i_type, invalid;
        logic [1:0]  mem, trd;
        logic [3:0]  jmp;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]  in_tid = '0;
    logic [31:0] in_ins = '0;
    logic [3:0]  flush = '0;
    logic        in_ready, out_valid, out_wr_en, out_init, out_exp_jmp, out_exp_return;
    logic        out_i_type, out_invalid;
    logic [3:0]  buf_full, halted, out_jmp_con;
    logic [1:0]  out_tid, out_mem_ctrl, out_trd_ctrl;
    logic [4:0]  out_reg_rd_a, out_reg_rd_b, out_reg_wr;
    logic [15:0] out_imm;
    logic [2:0]  out_alu_op;

    int   checks = 0, failures = 0;
    exp_t exp_q [4][$];
    int   obs_tids [$];

    decode_mt dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_tid(in_tid), .in_ins(in_ins),
        .in_ready(in_ready), .flush(flush), .buf_full(buf_full), .halted(halted),
        .out_valid(out_valid), .out_ready(out_ready), .out_tid(out_tid),
        .out_reg_rd_a(out_reg_rd_a), .out_reg_rd_b(out_reg_rd_b), .out_reg_wr(out_reg_wr),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_wr_en(out_wr_en), .out_init(out_init),
        .out_exp_jmp(out_exp_jmp), .out_exp_return(out_exp_return), .out_i_type(out_i_type),
        .out_invalid(out_invalid), .out_mem_ctrl(out_mem_ctrl), .out_trd_ctrl(out_trd_ctrl),
        .out_jmp_con(out_jmp_con)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] tid, input logic [31:0] w);
        exp_t e = '0;
        logic [3:0] op = w[4:1];
        logic [2:0] f  = w[7:5];
        e.tid = tid; e.rd_a = w[26:22]; e.wr = w[31:27]; e.imm = w[25:10]; e.alu = f;
        e.rd_b = (op == BRANCH || op == MEMOP) ? w[31:27] : w[21:17];
        if (op == CAL || op == SHIFT) e.wr_en = 1;
        else if (op == CALI || op == LOADI) begin e.wr_en = 1; e.i_type = 1; end
        else if (op == MEMOP) begin
            e.i_type = 1;
            if (w[8]) begin e.mem = 2'b01; e.wr_en = 1; end else e.mem = 2'b10;
        end else if (op == BRANCH) begin
            if (f == 3'b000)      begin e.jmp = 4'b0111; e.wr_en = 1; end
            else if (f == 3'b010) begin e.jmp = 4'b1111; e.wr_en = 1; end
            else if (f == 3'b001) e.jmp = 4'b0001;
            else if (f == 3'b011) e.jmp = 4'b0100;
            else if (f == 3'b111) e.jmp = 4'b0010;
            else e.invalid = 1;
        end else if (op == EXC) begin
            if (w[5]) e.exp_jmp = 1; else if (w[6]) e.exp_ret = 1; else e.invalid = 1;
        end else if (op == MULTI) begin
            if (f == 3'b111)      begin e.init = 1; e.wr_en = 1; end
            else if (f == 3'b101) e.trd = 2'b01;
            else if (f == 3'b010) e.trd = 2'b10;
            else if (f == 3'b000) e.trd = 2'b11;
            else e.invalid = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] f, input logic b8);
        logic [31:0] w = $urandom;
        w[4:1] = op; w[7:5] = f; w[8] = b8;
        return w;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int t = 0; t < 4; t++) n += exp_q[t].size();
        return n;
    endfunction

    // Sample mid-cycle (negedge), then advance to just past the next rising edge.
    task automatic cycle();
        exp_t obs;
        @(negedge clk);
        if (out_valid && out_ready) begin
            obs = {out_tid, out_reg_rd_a, out_reg_rd_b, out_reg_wr, out_imm, out_alu_op,
                   out_wr_en, out_init, out_exp_jmp, out_exp_return, out_i_type, out_invalid,
                   out_mem_ctrl, out_trd_ctrl, out_jmp_con};
            obs_tids.push_back(int'(out_tid));
            check("exp_avail", 64'(exp_q[out_tid].size() != 0), 1);
            if (exp_q[out_tid].size() != 0) check("slot", 64'(obs), 64'(exp_q[out_tid].pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int tid, input logic [31:0] w, input bit expect_out);
        in_valid = 1; in_tid = 2'(tid); in_ins = w;
        #1;
        check("push_in_ready", 64'(in_ready), 1);
        if (expect_out) exp_q[tid].push_back(model(2'(tid), w));
        cycle();
        in_valid = 0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() > 0 && n < budget) begin cycle(); n++; end
        check("drain_left", 64'(pending()), 0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_halted", 64'(halted), 0);
        check("rst_buf_full", 64'(buf_full), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_imm", 64'(out_imm), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // CALI latency: visible after the edge following the push
        out_ready = 1;
        push(2, mk(CALI, 3'b011, 0), 1);
        check("lat_valid_early", 64'(out_valid), 0);
        cycle();
        check("lat_valid", 64'(out_valid), 1);
        check("lat_tid", 64'(out_tid), 2);
        check("lat_wr_en_itype", 64'({out_wr_en, out_i_type}), 2'b11);
        drain(4);

        // Decode table sweep (valid encodings only) on one thread
        push(2, mk(CAL, 3'b101, 0), 1);   push(2, mk(SHIFT, 3'b010, 1), 1);
        push(2, mk(LOADI, 3'b000, 0), 1); push(2, mk(MEMOP, 3'b000, 1), 1);
        push(2, mk(MEMOP, 3'b110, 0), 1); push(2, mk(BRANCH, 3'b000, 0), 1);
        push(2, mk(BRANCH, 3'b010, 0), 1); push(2, mk(BRANCH, 3'b001, 0), 1);
        push(2, mk(BRANCH, 3'b011, 0), 1); push(2, mk(BRANCH, 3'b111, 0), 1);
        push(2, mk(EXC, 3'b001, 0), 1);   push(2, mk(EXC, 3'b010, 0), 1);
        push(2, mk(MULTI, 3'b111, 0), 1); push(2, mk(MULTI, 3'b101, 0), 1);
        push(2, mk(MULTI, 3'b010, 0), 1); push(2, mk(MULTI, 3'b000, 0), 1);
        push(2, mk(4'd0, 3'b100, 1), 1);  push(2, mk(4'd15, 3'b011, 0), 1);
        drain(8);

        // Fill thread 0 while the slot is stalled, then release
        out_ready = 0;
        for (int i = 0; i < 5; i++) push(0, mk(CAL, 3'(i), 0), 1);
        in_tid = 0; #1;
        check("full_bit", 64'(buf_full), 4'b0001);
        check("full_in_ready0", 64'(in_ready), 0);
        in_tid = 1; #1;
        check("full_in_ready1", 64'(in_ready), 1);
        out_ready = 1;
        drain(10);

        // Round-robin across four threads
        out_ready = 0;
        obs_tids.delete();
        for (int t = 0; t < 4; t++) begin
            push(t, mk(SHIFT, 3'b001, 0), 1);
            push(t, mk(CAL, 3'b110, 0), 1);
        end
        out_ready = 1;
        drain(12);
        check("rr_count", 64'(obs_tids.size()), 8);
        for (int i = 0; i < 8 && i < obs_tids.size(); i++) check("rr_tid", 64'(obs_tids[i]), 64'(i % 4));

        // Invalid branch halts thread 1; the following CAL must never appear
        push(1, mk(BRANCH, 3'b100, 0), 1);
        push(1, mk(CAL, 3'b000, 0), 0);
        repeat (3) cycle();
        check("halt_set", 64'(halted), 4'b0010);
        check("halt_no_out", 64'(out_valid), 0);
        flush = 4'b0010; in_tid = 1; #1;
        check("flush_in_ready", 64'(in_ready), 0);
        cycle();
        flush = 0;
        check("halt_clear", 64'(halted), 0);
        repeat (3) cycle();
        check("flush_empty", 64'(out_valid), 0);

        // Two threads halt, one multi-bit flush releases both
        push(3, mk(EXC, 3'b000, 0), 1);
        push(0, mk(MULTI, 3'b011, 0), 1);
        drain(4);
        cycle();
        check("halt_two", 64'(halted), 4'b1001);
        flush = 4'b1001;
        cycle();
        flush = 0;
        check("halt_two_clear", 64'(halted), 0);

        // Flush of the stalled slot's thread lets thread 0 take the slot
        out_ready = 0;
        push(3, mk(CAL, 3'b001, 0), 1);
        push(0, mk(CALI, 3'b010, 0), 1);
        check("slot_t3", 64'({out_valid, out_tid}), 3'b111);
        flush = 4'b1000;
        cycle();
        flush = 0;
        exp_q[3].delete();
        check("slot_t0_after_flush", 64'({out_valid, out_tid}), 3'b100);
        out_ready = 1;
        drain(4);

        // Asynchronous reset mid-stream with three buffered entries
        out_ready = 0;
        for (int i = 0; i < 4; i++) push(2, mk(LOADI, 3'(i), 0), 1);
        #2 rst_n = 0;
        #1;
        check("arst_valid", 64'(out_valid), 0);
        check("arst_imm", 64'(out_imm), 0);
        check("arst_buf_full", 64'(buf_full), 0);
        for (int t = 0; t < 4; t++) exp_q[t].delete();
        #3 rst_n = 1;
        @(posedge clk); #1;
        out_ready = 1;
        repeat (4) cycle();
        check("arst_stays_empty", 64'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
